// File: rtl/fc1_csr_fanout.sv
// CSR fan-out/fan-in for the FC1 KR channel array.
// One upstream CSR master reaches CHANNELS per-channel CSR slaves. The top
// address bits select the channel. The all-ones channel value is a
// broadcast write. Only one read is ever outstanding.
//
// Upstream handshake: iCSR_WR_EN and iCSR_RD_EN are one-cycle strobes with no
// back-pressure. A request is accepted only in IDLE and only while oCSR_BUSY
// is low; any other request is dropped and counted. Each accepted read gets
// exactly one oCSR_RD_DATA_V pulse. That pulse can carry oCSR_ERR. The only
// exception is a reset, which abandons the outstanding read silently.
module fc1_csr_fanout #(
    parameter int                CHANNELS = 26,
    parameter int                ADDR_W   = 10,
    parameter int                DATA_W   = 64,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = 64'hDEAD_DEAD_DEAD_DEAD,
    localparam int               CH_SEL_W = $clog2(CHANNELS + 1),
    localparam int               CH_BCAST = 2**CH_SEL_W - 1
) (
    input  logic                         iCLK_CORE_219,
    input  logic                         iRST_CORE_219_N,
    input  logic                         iCSR_WR_EN,
    input  logic                         iCSR_RD_EN,
    input  logic [CH_SEL_W+ADDR_W-1:0]   iCSR_ADDR,
    input  logic [DATA_W-1:0]            iCSR_WR_DATA,
    output logic [DATA_W-1:0]            oCSR_RD_DATA,
    output logic                         oCSR_RD_DATA_V,
    output logic                         oCSR_BUSY,
    output logic                         oCSR_ERR,
    output logic [7:0]                   oTIMEOUT_CNT,
    output logic [7:0]                   oDROP_CNT,
    output logic [CHANNELS-1:0]          oCH_CSR_WR_EN,
    output logic [CHANNELS-1:0]          oCH_CSR_RD_EN,
    output logic [ADDR_W-1:0]            oCH_CSR_ADDR,
    output logic [DATA_W-1:0]            oCH_CSR_WR_DATA,
    input  logic [CHANNELS*DATA_W-1:0]   iCH_CSR_RD_DATA,
    input  logic [CHANNELS-1:0]          iCH_CSR_RD_DATA_V,
    output logic [1:0]                   oDBG_STATE
);

    localparam int                  TW       = $clog2(TIMEOUT + 1);
    localparam logic [CH_SEL_W-1:0] CH_LAST  = CH_SEL_W'(CHANNELS - 1);
    localparam logic [CH_SEL_W-1:0] CH_BC_V  = CH_SEL_W'(CH_BCAST);
    localparam logic [TW-1:0]       TMR_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_RD_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [CH_SEL_W-1:0]   r_sel;
    logic [TW-1:0]         r_timer;
    logic                  r_err;
    logic [DATA_W-1:0]     r_rdata;
    logic [7:0]            r_timeout_cnt;
    logic [7:0]            r_drop_cnt;
    logic [CHANNELS-1:0]   r_wr_en;
    logic [CHANNELS-1:0]   r_rd_en;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;

    logic [CH_SEL_W-1:0]   w_ch;
    logic [ADDR_W-1:0]     w_reg;
    logic                  w_ch_valid;
    logic                  w_ch_bcast;
    logic [CHANNELS-1:0]   w_onehot;
    logic [DATA_W-1:0]     w_sel_data;
    logic                  w_rd_hit;
    logic                  w_wr_go;
    logic                  w_rd_go;
    logic                  w_rd_err;
    logic                  w_timeout;
    logic                  w_drop;

    assign w_ch       = iCSR_ADDR[ADDR_W +: CH_SEL_W];
    assign w_reg      = iCSR_ADDR[ADDR_W-1:0];
    assign w_ch_valid = (w_ch <= CH_LAST);
    assign w_ch_bcast = (w_ch == CH_BC_V);
    assign w_onehot   = CHANNELS'(1) << w_ch;
    assign w_sel_data = iCH_CSR_RD_DATA[int'(r_sel)*DATA_W +: DATA_W];
    // The cycle that carries the downstream read strobe has timer 0. A valid
    // in that cycle cannot answer this read, so it is ignored.
    assign w_rd_hit   = (r_state == S_RD_WAIT) && (r_timer != '0) && iCH_CSR_RD_DATA_V[r_sel];

    // FSM state register
    always_ff @(posedge iCLK_CORE_219) begin
        if (!iRST_CORE_219_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, request accept/drop decisions and upstream status outputs
    always_comb begin
        w_state_nxt    = r_state;
        w_wr_go        = 1'b0;
        w_rd_go        = 1'b0;
        w_rd_err       = 1'b0;
        w_timeout      = 1'b0;
        w_drop         = 1'b0;
        oCSR_BUSY      = 1'b0;
        oCSR_RD_DATA_V = 1'b0;
        oCSR_ERR       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (iCSR_WR_EN) begin
                    // A write wins over a simultaneous read; the read is dropped.
                    if (w_ch_valid || w_ch_bcast) w_wr_go = 1'b1;
                    else                          w_drop  = 1'b1;
                    if (iCSR_RD_EN)               w_drop  = 1'b1;
                end else if (iCSR_RD_EN) begin
                    if (w_ch_valid) begin
                        w_rd_go     = 1'b1;
                        w_state_nxt = S_RD_WAIT;
                    end else begin
                        w_rd_err    = 1'b1;
                        w_state_nxt = S_RD_RESP;
                    end
                end
            end
            S_RD_WAIT: begin
                oCSR_BUSY = 1'b1;
                w_drop    = iCSR_WR_EN || iCSR_RD_EN;
                if (w_rd_hit) begin
                    w_state_nxt = S_RD_RESP;
                end else if (r_timer == TMR_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_RD_RESP;
                end
            end
            S_RD_RESP: begin
                oCSR_RD_DATA_V = 1'b1;
                oCSR_ERR       = r_err;
                w_drop         = iCSR_WR_EN || iCSR_RD_EN;
                w_state_nxt    = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Downstream strobes, shared address/data, read capture, timer and counters
    always_ff @(posedge iCLK_CORE_219) begin
        if (!iRST_CORE_219_N) begin
            r_wr_en       <= '0;
            r_rd_en       <= '0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_sel         <= '0;
            r_timer       <= '0;
            r_err         <= 1'b0;
            r_rdata       <= '0;
            r_timeout_cnt <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_wr_en <= '0;
            r_rd_en <= '0;
            if (w_wr_go) begin
                r_wr_en <= w_ch_bcast ? '1 : w_onehot;
                r_addr  <= w_reg;
                r_wdata <= iCSR_WR_DATA;
            end
            if (w_rd_go) begin
                r_rd_en <= w_onehot;
                r_addr  <= w_reg;
                r_sel   <= w_ch;
                r_timer <= '0;
            end else if (r_state == S_RD_WAIT) begin
                r_timer <= r_timer + TW'(1);
            end
            if (w_rd_hit) begin
                r_rdata <= w_sel_data;
                r_err   <= 1'b0;
            end else if (w_timeout || w_rd_err) begin
                r_rdata <= ERR_DATA;
                r_err   <= 1'b1;
            end
            if (w_timeout && r_timeout_cnt != 8'hFF) r_timeout_cnt <= r_timeout_cnt + 8'd1;
            if (w_drop && r_drop_cnt != 8'hFF)       r_drop_cnt    <= r_drop_cnt + 8'd1;
        end
    end

    assign oCSR_RD_DATA    = r_rdata;
    assign oTIMEOUT_CNT    = r_timeout_cnt;
    assign oDROP_CNT       = r_drop_cnt;
    assign oCH_CSR_WR_EN   = r_wr_en;
    assign oCH_CSR_RD_EN   = r_rd_en;
    assign oCH_CSR_ADDR    = r_addr;
    assign oCH_CSR_WR_DATA = r_wdata;
    assign oDBG_STATE      = r_state;

endmodule

// File: doc/fc1_csr_fanout.md
Name: fc1_csr_fanout

Overview:
- Parametrised CSR fan-out/fan-in for the FC1 KR channel array; replaces the flat per-channel replication of one CSR bus.
- A single upstream CSR master addresses any of CHANNELS per-channel CSR slaves (encoder/decoder/PCS) by a channel field in the address.
- Supports unicast write/read, broadcast write, read-return muxing, read timeout and error/drop accounting.
- Sits between the board register block and the per-channel FC1 layer instances.

Parameters:
- CHANNELS, 26, number of downstream channel CSR slaves (1..CH_BCAST).
- ADDR_W, 10, per-channel register address width.
- DATA_W, 64, CSR data width.
- CH_SEL_W, $clog2(CHANNELS+1), channel-select field width (derived, not overridden).
- CH_BCAST, 2**CH_SEL_W-1, channel-select value meaning broadcast (derived).
- TIMEOUT, 255, read-response timeout in clocks (≥2).
- ERR_DATA, 64'hDEAD_DEAD_DEAD_DEAD, read data returned on error or timeout.

Ports:
- iCLK_CORE_219  in  1  core clock
- iRST_CORE_219_N  in  1  synchronous active-low reset
- iCSR_WR_EN  in  1  upstream write strobe, one cycle
- iCSR_RD_EN  in  1  upstream read strobe, one cycle
- iCSR_ADDR  in  CH_SEL_W+ADDR_W  {channel, reg address}
- iCSR_WR_DATA  in  DATA_W  write data
- oCSR_RD_DATA  out  DATA_W  read data, held until the next response
- oCSR_RD_DATA_V  out  1  read response valid, one-cycle pulse
- oCSR_BUSY  out  1  read outstanding
- oCSR_ERR  out  1  one-cycle pulse with an error/timeout response
- oTIMEOUT_CNT  out  8  saturating count of timeouts
- oDROP_CNT  out  8  saturating count of dropped requests
- oCH_CSR_WR_EN  out  CHANNELS  per-channel write strobe
- oCH_CSR_RD_EN  out  CHANNELS  per-channel read strobe
- oCH_CSR_ADDR  out  ADDR_W  shared registered address
- oCH_CSR_WR_DATA  out  DATA_W  shared registered write data
- iCH_CSR_RD_DATA  in  CHANNELS x DATA_W  per-channel read data
- iCH_CSR_RD_DATA_V  in  CHANNELS  per-channel read valid

Behaviour:
- Clocking and reset: one clock, iCLK_CORE_219. iRST_CORE_219_N is synchronous and active-low.
- Reset values: every output is 0 (including oCSR_RD_DATA and both counters). FSM goes to IDLE.
- Reset mid-read: the outstanding read is abandoned with no response. A valid arriving later is ignored.
- Address decode: ch = iCSR_ADDR[top CH_SEL_W bits]; reg = iCSR_ADDR[ADDR_W-1:0].
- Write, IDLE only, request at cycle T:
  - At T+1, oCH_CSR_ADDR/oCH_CSR_WR_DATA are registered and the write strobe pulses for one cycle.
  - ch<CHANNELS: only bit ch of oCH_CSR_WR_EN is set.
  - ch==CH_BCAST: all CHANNELS bits are set.
  - Otherwise (invalid channel): the write is dropped, oDROP_CNT increments, no strobe.
- FSM states: IDLE, RD_WAIT, RD_RESP.
- IDLE read at T:
  - ch<CHANNELS: oCH_CSR_RD_EN[ch] pulses at T+1. Latch sel=ch, clear timer, go to RD_WAIT. oCSR_BUSY=1 from T+1.
  - ch==CH_BCAST or invalid channel: no downstream strobe. Go to RD_RESP with data=ERR_DATA and err=1.
- RD_WAIT:
  - The timer increments every cycle.
  - iCH_CSR_RD_DATA_V[sel]=1 at cycle V: capture iCH_CSR_RD_DATA[sel], go to RD_RESP; the response appears at V+1.
  - A valid from any other channel is ignored.
  - The earliest accepted valid is the cycle after oCH_CSR_RD_EN.
  - Timer reaches TIMEOUT with no valid: go to RD_RESP with ERR_DATA and err=1, and oTIMEOUT_CNT increments.
  - If valid and timeout coincide, valid wins.
- RD_RESP (one cycle): oCSR_RD_DATA_V=1, oCSR_ERR=err, oCSR_RD_DATA updated. oCSR_BUSY=0. Next state IDLE.
- New requests are accepted again from the cycle after RD_RESP.
- Dropping: any request (wr or rd) presented in RD_WAIT or RD_RESP is dropped and oDROP_CNT increments.
- Simultaneous wr+rd in IDLE: the write executes, the read is dropped, and oDROP_CNT increments by 1.
- Late valids: a valid arriving after timeout or in IDLE is ignored.
- Counters saturate at 255 and never wrap.
- Only one read is ever outstanding.

Test Plan:
- Unicast write, ch=3, reg=0x12A, data=0x0123456789ABCDEF at T -> oCH_CSR_WR_EN=1<<3 for exactly one cycle at T+1, oCH_CSR_ADDR=0x12A, WR_DATA matches.
- Broadcast write, ch=31 -> all 26 WR_EN bits high at T+1. ch=28 -> no strobe, oDROP_CNT=1.
- Unicast read, ch=25; slave returns 0xCAFE with valid 4 cycles after RD_EN -> oCSR_RD_DATA_V one cycle later with data 0xCAFE, oCSR_ERR=0. BUSY is high throughout the wait.
- Read ch=7 with no slave response; channel 6 pulses valid during the wait -> timeout response at cycle TIMEOUT with DEAD_DEAD_DEAD_DEAD, oCSR_ERR=1, oTIMEOUT_CNT=1. The channel 6 valid is ignored.
- A write issued while BUSY, plus wr+rd issued together in IDLE -> oDROP_CNT=2, and only the IDLE write reaches its channel. 300 invalid writes -> oDROP_CNT saturates at 255.
- Reset asserted in RD_WAIT, then the slave valid arrives -> no oCSR_RD_DATA_V, all outputs 0, next read is served normally.
